// File: rtl/vector_mem_responder.sv
// Word-addressed memory responder for per-lane vector accesses.
// One request at a time, WAIT wait states, then a one-cycle ready pulse.
module vector_mem_responder #(
  parameter int N     = 32,
  parameter int DEPTH = 256,
  parameter int WAIT  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req,
  input  logic         mem_wen,
  input  logic [N-1:0] m_address,
  input  logic [N-1:0] to_mem_data,
  output logic [N-1:0] mem_data,
  output logic         ready,
  output logic         busy,
  output logic         err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [N:0] DEPTH_W = (N+1)'(DEPTH);
  localparam logic [3:0] WAIT_LD =
    (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t       state_q;
  logic [3:0]   cnt_q;
  logic         wen_q;
  logic [N-1:0] addr_q;
  logic [N-1:0] wdata_q;
  logic [N-1:0] mem_data_q;
  logic         ready_q;
  logic         busy_q;
  logic         err_q;

  logic [N-1:0] ram [DEPTH];

  logic         go_resp;
  logic [N-1:0] rd_addr;
  logic         rd_wen;
  logic         rd_ok;
  logic         wr_ok;

  function automatic logic in_range(
    input logic [N-1:0] a
  );
    return {1'b0, a} < DEPTH_W;
  endfunction

  // With no wait states the response is entered straight from
  // IDLE, so the request being latched is taken from the ports.
  always_comb begin
    go_resp = 1'b0;
    rd_addr = addr_q;
    rd_wen  = wen_q;
    if (state_q == S_IDLE) begin
      rd_addr = m_address;
      rd_wen  = mem_wen;
      go_resp = req && (WAIT == 0);
    end else if (state_q == S_WAIT) begin
      go_resp = (cnt_q == 4'd0);
    end
  end

  assign rd_ok = in_range(rd_addr);
  assign wr_ok = in_range(addr_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_data_q <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            wen_q   <= mem_wen;
            addr_q  <= m_address;
            wdata_q <= to_mem_data;
            busy_q  <= 1'b1;
            if (WAIT == 0) begin
              state_q <= S_RESP;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= WAIT_LD;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      if (go_resp) begin
        ready_q <= 1'b1;
        err_q   <= !rd_ok;
        if (!rd_wen) begin
          mem_data_q <= rd_ok ?
            ram[rd_addr[AW-1:0]] : '0;
        end
      end
    end
  end

  // Commit happens on the edge leaving RESP; an async reset
  // before then drops state to IDLE and the write is lost.
  always_ff @(posedge clk) begin
    if (state_q == S_RESP && wen_q && wr_ok) begin
      ram[addr_q[AW-1:0]] <= wdata_q;
    end
  end

  assign mem_data = mem_data_q;
  assign ready    = ready_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule
